// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit order and the
// gfedcba pattern table for the hex digits 0..F.
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_G = SEG_W - 1;

  // Entry i is the exact pattern that decodes to nibble i.
  localparam logic [15:0][SEG_W-1:0] SEG_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7tohex.sv
// Combinational exact-match decode of an active-high gfedcba segment pattern
// into a hex nibble; any pattern outside the table is flagged illegal.
module seg7tohex
  import seg7_pkg::*;
(
  input  logic [SEG_G:SEG_A] seg,
  output logic [3:0]         nibble,
  output logic               legal
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERNS[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a hex value from a multiplexed 7-segment display scan: each digit is
// captured once after its select/segment lines have been stable long enough.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIG           = 4,
  parameter int STABLE         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NDIG-1:0]   digit_en,
  input  logic [SEG_W-1:0]  segments,
  output logic [NDIG*4-1:0] value,
  output logic [NDIG-1:0]   digit_ok,
  output logic              valid,
  output logic              error,
  output logic              frame_done
);

  localparam int         SW      = NDIG + SEG_W;
  localparam logic [3:0] CNT_MAX = 4'(STABLE - 1);
  localparam logic [3:0] CAP_AT  = 4'(STABLE - 2);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic [SW-1:0]          sample_q, sample_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   captured_q, captured_d;
  logic [NDIG-1:0][3:0]   nib_q, nib_d;
  logic [NDIG-1:0]        ok_q, ok_d;
  logic                   error_q, error_d;
  logic                   frame_done_q, frame_done_d;

  logic [SEG_W-1:0] seg_in;
  logic [3:0]       dec_nib;
  logic             legal;
  logic             match, blank, onehot, fire;

  assign seg_in = SEG_ACTIVE_LOW ? ~segments : segments;

  seg7tohex u_dec (
    .seg    (seg_in),
    .nibble (dec_nib),
    .legal  (legal)
  );

  always_comb begin
    sample_d = {digit_en, segments};
    match    = (sample_d == sample_q);
    blank    = (digit_en == '0);
    onehot   = !blank && ((digit_en & (digit_en - NDIG'(1))) == '0);
    // captured_q keeps a saturated dwell from firing again until inputs change.
    fire     = match && !blank && !captured_q && (cnt_q >= CAP_AT);

    cnt_d      = '0;
    captured_d = 1'b0;
    if (match && !blank) begin
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
      captured_d = captured_q | fire;
    end

    nib_d        = nib_q;
    ok_d         = ok_q;
    error_d      = 1'b0;
    frame_done_d = 1'b0;
    if (fire) begin
      if (onehot && legal) begin
        for (int i = 0; i < NDIG; i++) begin
          if (digit_en[i]) begin
            nib_d[i] = dec_nib;
            ok_d[i]  = 1'b1;
          end
        end
        frame_done_d = digit_en[NDIG-1] && (&ok_d);
      end else begin
        error_d = 1'b1;
        if (onehot) ok_d = ok_q & ~digit_en;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sample_q     <= '0;
      cnt_q        <= '0;
      captured_q   <= 1'b0;
      nib_q        <= '0;
      ok_q         <= '0;
      error_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sample_q     <= sample_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      nib_q        <= nib_d;
      ok_q         <= ok_d;
      error_q      <= error_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign value      = nib_q;
  assign digit_ok   = ok_q;
  assign valid      = &ok_q;
  assign error      = error_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NDIG=4, STABLE=3): a run-length model
// pushes expected outputs per edge, which are compared at the following negedge.
module tb_seg7_scan_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic        clock;
  logic        reset;
  logic [3:0]  digit_en;
  logic [6:0]  segments;
  logic [15:0] value;
  logic [3:0]  digit_ok;
  logic        valid, error, frame_done;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .digit_en   (digit_en),
    .segments   (segments),
    .value      (value),
    .digit_ok   (digit_ok),
    .valid      (valid),
    .error      (error),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  ok;
    logic        valid;
    logic        err;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  logic [6:0]  tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [10:0] m_prev;
  int          run;
  logic [15:0] m_val;
  logic [3:0]  m_ok;
  int          n_chk, n_fail, cyc, fd_seen, err_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock of stimulus: model the edge, queue the expectation, check at negedge.
  task automatic step(input logic [3:0] en, input logic [6:0] sg);
    exp_t e;
    logic leg;
    logic [3:0] nb;
    int idx;
    digit_en = en;
    segments = sg;
    @(posedge clock);
    cyc++;
    if ({en, sg} == m_prev) run = (run < 100) ? run + 1 : 100;
    else run = 1;
    m_prev = {en, sg};
    e.err = 1'b0;
    e.fd  = 1'b0;
    if (en != 4'b0 && run == STABLE) begin
      leg = 1'b0; nb = 4'h0; idx = 0;
      for (int k = 0; k < 16; k++) if (tbl[k] == sg) begin leg = 1'b1; nb = 4'(k); end
      for (int j = 0; j < NDIG; j++) if (en[j]) idx = j;
      if ($countones(en) == 1 && leg) begin
        m_val[idx*4 +: 4] = nb;
        m_ok[idx] = 1'b1;
        e.fd = (idx == NDIG - 1) && (&m_ok);
      end else begin
        e.err = 1'b1;
        if ($countones(en) == 1) m_ok[idx] = 1'b0;
      end
    end
    e.value = m_val;
    e.ok    = m_ok;
    e.valid = &m_ok;
    sb.push_back(e);
    @(negedge clock);
    e = sb.pop_front();
    if (frame_done) fd_seen++;
    if (error) err_seen++;
    chk("value", 32'(value), 32'(e.value));
    chk("digit_ok", 32'(digit_ok), 32'(e.ok));
    chk("valid", 32'(valid), 32'(e.valid));
    chk("error", 32'(error), 32'(e.err));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
  endtask

  task automatic present(input logic [3:0] en, input logic [6:0] sg, input int n);
    repeat (n) step(en, sg);
  endtask

  initial begin
    int got_k;
    logic [3:0] ren;
    logic [6:0] rsg;
    n_chk = 0; n_fail = 0; cyc = 0; fd_seen = 0; err_seen = 0;
    m_prev = '0; run = 0; m_val = '0; m_ok = '0;
    reset = 1'b0; digit_en = '0; segments = '0;
    #1;
    chk("reset_value", 32'(value), 0);
    chk("reset_flags", 32'({digit_ok, valid, error, frame_done}), 0);
    #22 reset = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);

    // Single digit capture after three stable edges
    present(4'b0001, 7'h5B, 3);
    chk("s1_nibble0", 32'(value[3:0]), 2);
    chk("s1_ok", 32'(digit_ok), 32'h1);

    // Full scan, one frame_done on the digit-3 capture
    fd_seen = 0;
    present(4'b0001, 7'h3F, 4);
    present(4'b0010, 7'h06, 4);
    present(4'b0100, 7'h5B, 4);
    present(4'b1000, 7'h4F, 4);
    chk("scan_value", 32'(value), 32'h3210);
    chk("scan_valid", 32'(valid), 1);
    chk("scan_fd_count", 32'(fd_seen), 1);

    // Glitch: short dwell discarded
    present(4'b0010, 7'h06, 2);
    present(4'b0010, 7'h5B, 3);
    chk("glitch_value", 32'(value), 32'h3220);

    // Illegal pattern on digit 2
    err_seen = 0;
    present(4'b0100, 7'h7E, 3);
    chk("illegal_err_count", 32'(err_seen), 1);
    chk("illegal_ok", 32'(digit_ok), 32'hB);
    chk("illegal_value", 32'(value), 32'h3220);

    // Multi-hot select then blanking
    err_seen = 0;
    present(4'b0011, 7'h06, 5);
    present(4'b0000, 7'h00, 10);
    chk("multihot_err_count", 32'(err_seen), 1);
    chk("multihot_value", 32'(value), 32'h3220);

    // Restore digit 2, long dwell on digit 3 completes a frame once
    fd_seen = 0;
    present(4'b0100, 7'h5B, 3);
    present(4'b1000, 7'h71, 6);
    chk("long_dwell_value", 32'(value), 32'hF220);
    chk("long_dwell_fd_count", 32'(fd_seen), 1);

    // Random dwells, mixing legal/illegal patterns and odd selects
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) ren = 4'($urandom_range(0, 15));
      else ren = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) rsg = 7'($urandom_range(0, 127));
      else rsg = tbl[$urandom_range(0, 15)];
      present(ren, rsg, $urandom_range(1, 5));
    end

    // Reset on the 2nd cycle of a dwell
    step(4'b0000, 7'h00);
    step(4'b0010, 7'h66);
    reset = 1'b0;
    #1;
    chk("rst_async_value", 32'(value), 0);
    chk("rst_async_flags", 32'({digit_ok, valid, error, frame_done}), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    got_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (digit_ok[1] && got_k == 0) got_k = k;
    end
    chk("rst_capture_seen", 32'(got_k != 0), 1);
    chk("rst_fresh_dwell", 32'(got_k >= STABLE), 1);
    chk("rst_value", 32'(value), 32'h0040);
    m_val = 16'h0040; m_ok = 4'b0010; m_prev = {4'b0010, 7'h66}; run = 100;
    present(4'b0010, 7'h66, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
